// File: rtl/five_bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package five_bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 5;

    // Bit-position counter width; at least one bit even for WIDTH=1.
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/five_bit_serial_adder_full_adder_cell.sv
// Combinational 1-bit full adder used by the serial datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/five_bit_serial_adder.sv
// LSB-first bit-serial adder with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port (a + ~b + 1).
module five_bit_serial_adder
    import five_bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   sum_q;
    logic             busy_q;
    logic             done_q;
    logic             inv_q;

    logic             fa_y;
    logic             fa_s;
    logic             fa_cout;
    logic             last;
    logic [WIDTH:0]   sum_d;
    logic             carry_in_d;
    logic             inv_d;

`ifdef SERIAL_ADDER_SUB_EN
    assign inv_d      = sub;
    assign carry_in_d = sub;
`else
    assign inv_d      = 1'b0;
    assign carry_in_d = 1'b0;
`endif

    // In subtract mode b is inverted bit by bit as it reaches the adder.
    assign fa_y = b_q[0] ^ inv_q;
    assign last = (count_q == LAST);

    full_adder_cell u_fa (
        .x    (a_q[0]),
        .y    (fa_y),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        sum_d = {1'b0, fa_s, sum_q[WIDTH-1:1]};
        if (last) begin
            sum_d[WIDTH] = fa_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        inv_q   <= inv_d;
                        carry_q <= carry_in_d;
                        count_q <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    count_q <= count_q + 1'b1;
                    sum_q   <= sum_d;
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_five_bit_serial_adder.sv
// Scoreboard bench for five_bit_serial_adder (random + directed).
module tb_five_bit_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] a = '0;
    logic [4:0] b = '0;
    logic       sub_r = 1'b0;
    logic       busy;
    logic       done;
    logic [5:0] sum;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    five_bit_serial_adder dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [5:0] model(input int x, input int y, input bit s);
        int r;
        if (s) r = ((x >= y) ? 32 : 0) + ((x - y + 32) % 32);
        else   r = x + y;
        return 6'(r);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got sum=%0d, expected no done", sum);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if (sum != e) begin
                    errors++;
                    $display("FAIL sum: got %0d, expected %0d", sum, e);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] x, input logic [4:0] y, input bit s);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_wait", 1, 0);
        start = 1'b1;
        a = x;
        b = y;
        sub_r = s;
        exp_q.push_back(model(int'(x), int'(y), s));
        @(negedge clk);
        start = 1'b0;
        a = 5'($urandom);
        b = 5'($urandom);
        sub_r = 1'($urandom);
    endtask

    task automatic timed(input logic [4:0] x, input logic [4:0] y, input bit s,
                         input int req);
        int lat;
        int bn;
        lat = 0;
        bn = 0;
        issue(x, y, s);
        for (int k = 1; k <= 20; k++) begin
            if (busy) bn++;
            if (done) begin
                lat = k;
                check("done_sum", int'(sum), req);
                break;
            end
            @(negedge clk);
        end
        check("latency", lat, 6);
        check("busy_cycles", bn, 6);
        @(negedge clk);
        check("busy_after", int'(busy), 0);
        check("sum_held", int'(sum), req);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        rst = 1'b0;
        @(negedge clk);

        timed(5'd15, 5'd15, 1'b0, 30);
        timed(5'd31, 5'd31, 1'b0, 62);
        timed(5'd0, 5'd0, 1'b0, 0);

        // Round trip: (i-j) + j must rebuild i.
        for (int i = 1; i <= 15; i++) begin
            for (int j = 1; j <= i; j++) begin
                issue(5'(i - j), 5'(j), 1'b0);
            end
        end
        drain();

        // Start during SHIFT must be ignored.
        d0 = done_cnt;
        issue(5'd7, 5'd9, 1'b0);
        start = 1'b1;
        a = 5'd31;
        b = 5'd31;
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("one_done", done_cnt - d0, 1);

        // Reset on the third SHIFT cycle aborts.
        d0 = done_cnt;
        issue(5'd20, 5'd21, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        rst = 1'b0;
        void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        timed(5'd20, 5'd21, 1'b0, 41);

        if (HAS_SUB) begin
            timed(5'd9, 5'd5, 1'b1, 6'b1_00100);
            timed(5'd5, 5'd9, 1'b1, 6'b0_11100);
            timed(5'd9, 5'd9, 1'b1, 6'b1_00000);
        end

        for (int t = 0; t < 60; t++) begin
            issue(5'($urandom), 5'($urandom), HAS_SUB ? 1'($urandom) : 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
